// File: rtl/intcalc_iter.sv
// Iterative integer calculation unit: shift-add multiply and restoring divide on
// operand magnitudes with a final sign fix-up, plus single-cycle unary ops.
package intcalc_pkg;

  typedef enum logic [3:0] {
    INT_MUL   = 4'd0,
    INT_DIV   = 4'd1,
    INT_MOD   = 4'd2,
    INT_MULU  = 4'd3,
    INT_DIVU  = 4'd4,
    INT_MODU  = 4'd5,
    INT_MULX  = 4'd6,
    INT_MULUX = 4'd7,
    INT_EXT   = 4'd8,
    INT_EXTB  = 4'd9,
    INT_COM   = 4'd10,
    INT_NEG   = 4'd11
  } intfunc_t;

endpackage

module intcalc_iter
  import intcalc_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  intfunc_t         func,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_o,
  output logic             div0_o
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_next;

  function automatic logic is_iter_op(input intfunc_t f);
    case (f)
      INT_MUL, INT_MULU, INT_MULX, INT_MULUX,
      INT_DIV, INT_DIVU, INT_MOD, INT_MODU: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(input intfunc_t f);
    case (f)
      INT_DIV, INT_DIVU, INT_MOD, INT_MODU: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

  function automatic logic is_signed_op(input intfunc_t f);
    case (f)
      INT_MUL, INT_MULX, INT_DIV, INT_MOD: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

  // Datapath registers: hi:lo is the product / remainder:quotient pair, dv the
  // multiplicand or divisor magnitude.
  intfunc_t         func_q;
  logic [WIDTH-1:0] a_q;
  logic             bz_q;
  logic             sa_q;
  logic             sb_q;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] dv;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             in_sa;
  logic             in_sb;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] simple_res;

  always_comb begin
    accept = (state == IDLE) && in_valid && !flush_i;
    in_sa  = is_signed_op(func) && a_i[WIDTH-1];
    in_sb  = is_signed_op(func) && b_i[WIDTH-1];
    mag_a  = in_sa ? -a_i : a_i;
    mag_b  = in_sb ? -b_i : b_i;
  end

  always_comb begin
    simple_res = '0;
    case (func)
      INT_EXT:  simple_res = WIDTH'($signed(b_i[15:0]));
      INT_EXTB: simple_res = WIDTH'($signed(b_i[7:0]));
      INT_COM:  simple_res = ~b_i;
      INT_NEG:  simple_res = -b_i;
      default:  simple_res = '0;
    endcase
  end

  // One iteration step for each algorithm.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;

  always_comb begin
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, dv} : '0);
    div_sh   = {hi, lo[WIDTH-1]};
    div_ge   = div_sh >= {1'b0, dv};
    div_diff = div_sh[WIDTH-1:0] - dv;
  end

  // Sign fix-up and result selection, committed on the FIXUP -> DONE edge.
  logic [W2-1:0]    prod;
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic             fix_div0;
  logic [WIDTH-1:0] fix_res;

  always_comb begin
    prod     = {hi, lo};
    prod_fix = (sa_q ^ sb_q) ? -prod : prod;
    quot     = (sa_q ^ sb_q) ? -lo : lo;
    rem      = sa_q ? -hi : hi;
    fix_div0 = is_div_op(func_q) && bz_q;
    fix_res  = '0;
    case (func_q)
      INT_MUL, INT_MULU:   fix_res = prod_fix[WIDTH-1:0];
      INT_MULX, INT_MULUX: fix_res = prod_fix[W2-1:WIDTH];
      INT_DIV, INT_DIVU:   fix_res = bz_q ? '1 : quot;
      INT_MOD, INT_MODU:   fix_res = bz_q ? a_q : rem;
      default:             fix_res = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    if (flush_i) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_next = is_iter_op(func) ? CALC : DONE;
        CALC:    if (cnt == CW'(WIDTH - 1)) state_next = FIXUP;
        FIXUP:   state_next = DONE;
        DONE:    if (out_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      func_q   <= intfunc_t'(4'd0);
      a_q      <= '0;
      bz_q     <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      dv       <= '0;
      cnt      <= '0;
      result_o <= '0;
      div0_o   <= 1'b0;
    end else if (accept) begin
      func_q <= func;
      a_q    <= a_i;
      bz_q   <= (b_i == '0);
      sa_q   <= in_sa;
      sb_q   <= in_sb;
      hi     <= '0;
      cnt    <= '0;
      if (is_div_op(func)) begin
        lo <= mag_a;
        dv <= mag_b;
      end else begin
        lo <= mag_b;
        dv <= mag_a;
      end
      if (!is_iter_op(func)) begin
        result_o <= simple_res;
        div0_o   <= 1'b0;
      end
    end else if (state == CALC && !flush_i) begin
      cnt <= cnt + CW'(1);
      if (is_div_op(func_q)) begin
        hi <= div_ge ? div_diff : div_sh[WIDTH-1:0];
        lo <= {lo[WIDTH-2:0], div_ge};
      end else begin
        hi <= mul_sum[WIDTH:1];
        lo <= {mul_sum[0], lo[WIDTH-1:1]};
      end
    end else if (state == FIXUP && !flush_i) begin
      result_o <= fix_res;
      div0_o   <= fix_div0;
    end
  end

endmodule

// File: tb/tb_intcalc_iter.sv
// Directed bench for intcalc_iter: a WIDTH=32 and a WIDTH=16 instance checked
// against hand-computed results, latencies and handshake behaviour.
module tb_intcalc_iter;
  import intcalc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  intfunc_t    func;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        div0;

  logic        flush16;
  logic        in_valid16;
  logic        in_ready16;
  intfunc_t    func16;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        out_valid16;
  logic        out_ready16;
  logic [15:0] result16;
  logic        div016;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] r;
  logic        d;
  int          lat;
  logic        seen;

  logic [15:0] sa16 [3] = '{16'h0003, 16'hFFFF, 16'h1234};
  logic [15:0] sb16 [3] = '{16'h0005, 16'hFFFF, 16'h0010};
  logic [15:0] ex16 [3] = '{16'h000F, 16'h0001, 16'h2340};

  intcalc_iter #(.WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush), .in_valid(in_valid),
    .in_ready(in_ready), .func(func), .a_i(a), .b_i(b), .out_valid(out_valid),
    .out_ready(out_ready), .result_o(result), .div0_o(div0)
  );

  intcalc_iter #(.WIDTH(16)) dut16 (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush16), .in_valid(in_valid16),
    .in_ready(in_ready16), .func(func16), .a_i(a16), .b_i(b16), .out_valid(out_valid16),
    .out_ready(out_ready16), .result_o(result16), .div0_o(div016)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Present one request at a negedge; lat counts clocks from the request cycle
  // until out_valid is seen.
  task automatic run32(input intfunc_t f, input logic [31:0] av, input logic [31:0] bv,
                       output logic [31:0] res, output logic d0, output int lt);
    int wt = 0;
    while (!in_ready && wt < 50) begin
      @(posedge clk); @(negedge clk); wt++;
    end
    in_valid = 1'b1; func = f; a = av; b = bv;
    lt = 0;
    do begin
      @(posedge clk); lt++;
      @(negedge clk); in_valid = 1'b0;
    end while (!out_valid && lt < 200);
    res = result; d0 = div0;
  endtask

  task automatic consume32();
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run16(input intfunc_t f, input logic [15:0] av, input logic [15:0] bv,
                       output logic [31:0] res, output int lt);
    int wt = 0;
    while (!in_ready16 && wt < 50) begin
      @(posedge clk); @(negedge clk); wt++;
    end
    in_valid16 = 1'b1; func16 = f; a16 = av; b16 = bv;
    lt = 0;
    do begin
      @(posedge clk); lt++;
      @(negedge clk); in_valid16 = 1'b0;
    end while (!out_valid16 && lt < 200);
    res = 32'(result16);
  endtask

  initial begin
    rst_i = 1'b0; flush = 1'b0; in_valid = 1'b0; func = INT_MUL;
    a = '0; b = '0; out_ready = 1'b0;
    flush16 = 1'b0; in_valid16 = 1'b0; func16 = INT_MUL;
    a16 = '0; b16 = '0; out_ready16 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_div0", 32'(div0), 32'h0);
    rst_i = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'h1);

    run32(INT_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, d, lat);
    chk("mulu_res", r, 32'h0000_0001);
    chk("mulu_lat", 32'(lat), 32'd34);
    consume32();
    run32(INT_MULUX, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, d, lat);
    chk("mulux_res", r, 32'hFFFF_FFFE);
    consume32();
    run32(INT_MULX, 32'hFFFF_FFFD, 32'h7FFF_FFFF, r, d, lat);
    chk("mulx_res", r, 32'hFFFF_FFFE);
    consume32();
    run32(INT_MUL, 32'hFFFF_FFFD, 32'h7FFF_FFFF, r, d, lat);
    chk("mul_res", r, 32'h8000_0003);
    consume32();
    run32(INT_DIV, 32'hFFFF_FFF9, 32'h0000_0002, r, d, lat);
    chk("div_res", r, 32'hFFFF_FFFD);
    chk("div_lat", 32'(lat), 32'd34);
    consume32();
    run32(INT_MOD, 32'hFFFF_FFF9, 32'h0000_0002, r, d, lat);
    chk("mod_res", r, 32'hFFFF_FFFF);
    consume32();

    run32(INT_DIVU, 32'd5, 32'd0, r, d, lat);
    chk("divu0_res", r, 32'hFFFF_FFFF);
    chk("divu0_div0", 32'(d), 32'h1);
    chk("divu0_lat", 32'(lat), 32'd34);
    consume32();

    // Simple ops: one-clock latency, div0 cleared, result held under backpressure.
    run32(INT_NEG, 32'h0, 32'h1, r, d, lat);
    chk("neg_res", r, 32'hFFFF_FFFF);
    chk("neg_lat", 32'(lat), 32'd1);
    chk("neg_div0", 32'(d), 32'h0);
    consume32();
    run32(INT_EXTB, 32'h0, 32'h0000_0080, r, d, lat);
    chk("extb_res", r, 32'hFFFF_FF80);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      chk("hold_result", result, 32'hFFFF_FF80);
      chk("hold_in_ready", 32'(in_ready), 32'h0);
    end
    consume32();
    run32(INT_EXT, 32'h0, 32'h1234_8000, r, d, lat);
    chk("ext_res", r, 32'hFFFF_8000);
    consume32();
    run32(INT_COM, 32'h0, 32'h0F0F_0F0F, r, d, lat);
    chk("com_res", r, 32'hF0F0_F0F0);
    consume32();
    run32(intfunc_t'(4'hF), 32'h1234_5678, 32'h9ABC_DEF0, r, d, lat);
    chk("undef_res", r, 32'h0);
    consume32();

    run32(INT_MOD, 32'hFFFF_FFFB, 32'd0, r, d, lat);
    chk("mod0_res", r, 32'hFFFF_FFFB);
    chk("mod0_div0", 32'(d), 32'h1);
    consume32();

    // Asynchronous reset in the middle of a multiply.
    in_valid = 1'b1; func = INT_MULU; a = 32'd7; b = 32'd9;
    @(posedge clk); @(negedge clk); in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'h0);
    chk("arst_result", result, 32'h0);
    chk("arst_div0", 32'(div0), 32'h0);
    @(negedge clk);
    rst_i = 1'b1;
    @(posedge clk); @(negedge clk);
    run32(INT_DIVU, 32'd100, 32'd7, r, d, lat);
    chk("divu_after_rst", r, 32'd14);
    chk("divu_after_rst_lat", 32'(lat), 32'd34);
    consume32();

    run32(INT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, r, d, lat);
    chk("div_ovf_res", r, 32'h8000_0000);
    chk("div_ovf_div0", 32'(d), 32'h0);
    consume32();
    run32(INT_MOD, 32'h8000_0000, 32'hFFFF_FFFF, r, d, lat);
    chk("mod_ovf_res", r, 32'h0);
    consume32();

    // Flush around iteration 10 of a multiply.
    in_valid = 1'b1; func = INT_MUL; a = 32'd123; b = 32'd456;
    @(posedge clk); @(negedge clk); in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); @(negedge clk);
    flush = 1'b0;
    chk("flush_in_ready", 32'(in_ready), 32'h1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("flush_no_valid", 32'(seen), 32'h0);

    // A request coinciding with flush is dropped.
    in_valid = 1'b1; flush = 1'b1; func = INT_NEG; b = 32'd1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_req_out_valid", 32'(out_valid), 32'h0);
    chk("flush_req_in_ready", 32'(in_ready), 32'h1);

    // WIDTH=16 instance.
    run16(INT_MULX, 16'h8000, 16'h8000, r, lat);
    chk("w16_mulx_res", r, 32'h0000_4000);
    chk("w16_mulx_lat", 32'(lat), 32'd18);
    out_ready16 = 1'b1;
    @(posedge clk); @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      run16(INT_MULU, sa16[i], sb16[i], r, lat);
      chk("w16_stream_res", r, 32'(ex16[i]));
      chk("w16_stream_lat", 32'(lat), 32'd18);
    end
    out_ready16 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
